// File: rtl/palabra_mayor_n.sv
// palabra_mayor_n: pipelined N-input unsigned max/min selector.
// Reports the winning value, the lowest index holding it, and a tie flag.
// The tree is stored heap-style: node 0 is the root, node n has children
// 2n+1 (lower indices) and 2n+2, and the leaves occupy nodes
// ENTRADAS-1 .. 2*ENTRADAS-2 in input order.
// Optional feature macro: PALABRA_MAYOR_EMPATE_EN builds the tie-flag logic;
// when it is undefined, pm_empate is tied to 0.
module palabra_mayor_n #(
    parameter int ANCHO    = 4,
    parameter int ENTRADAS = 4,
    localparam int NIVELES = $clog2(ENTRADAS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ENTRADAS*ANCHO-1:0] pm_datos,
    input  logic                      pm_valido_in,
    input  logic                      pm_modo_min,
    output logic [ANCHO-1:0]          pm_mayor,
    output logic [NIVELES-1:0]        pm_indice,
    output logic                      pm_empate,
    output logic                      pm_valido_out
);

    localparam int NODOS = 2 * ENTRADAS - 1;

    // Node payload registers; the root (node 0) doubles as the output stage.
    logic [ANCHO-1:0]   r_val [NODOS];
    logic [NIVELES-1:0] r_idx [NODOS];
    // Valid bit and mode per tree depth; depth NIVELES is the leaf stage.
    // Mode is identical across a level, so it is carried once per depth.
    logic [NIVELES:0]   r_vld;
    logic [NIVELES:1]   r_mod;

    // Next-state values and load enables per node.
    logic [ANCHO-1:0]   w_val_next [NODOS];
    logic [NIVELES-1:0] w_idx_next [NODOS];
    logic [NODOS-1:0]   w_en;

`ifdef PALABRA_MAYOR_EMPATE_EN
    logic [NODOS-1:0]   r_tie;
    logic [NODOS-1:0]   w_tie_next;
`endif

    // Leaves: capture each input word with its fixed index.
    for (genvar gi = 0; gi < ENTRADAS; gi++) begin : g_hoja
        assign w_en[ENTRADAS-1+gi]       = pm_valido_in;
        assign w_val_next[ENTRADAS-1+gi] = pm_datos[gi*ANCHO +: ANCHO];
        assign w_idx_next[ENTRADAS-1+gi] = NIVELES'(gi);
`ifdef PALABRA_MAYOR_EMPATE_EN
        assign w_tie_next[ENTRADAS-1+gi] = 1'b0;
`endif
    end

    // Internal nodes: pairwise compare, the left (lower index) node keeps equal values.
    for (genvar gi = 0; gi < NIVELES; gi++) begin : g_nivel
        for (genvar gj = 0; gj < (1 << gi); gj++) begin : g_nodo
            localparam int N = (1 << gi) - 1 + gj;
            localparam int L = 2 * N + 1;
            localparam int R = 2 * N + 2;
            logic w_der_gana;
            assign w_der_gana    = r_mod[gi+1] ? (r_val[R] < r_val[L])
                                               : (r_val[R] > r_val[L]);
            assign w_en[N]       = r_vld[gi+1];
            assign w_val_next[N] = w_der_gana ? r_val[R] : r_val[L];
            assign w_idx_next[N] = w_der_gana ? r_idx[R] : r_idx[L];
`ifdef PALABRA_MAYOR_EMPATE_EN
            assign w_tie_next[N] = (w_der_gana ? r_tie[R] : r_tie[L])
                                 | (r_val[L] == r_val[R]);
`endif
        end
    end

    // Valid shift, per-depth mode and node payloads; payloads hold when their level is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            r_mod <= '0;
            for (int n = 0; n < NODOS; n++) begin
                r_val[n] <= '0;
                r_idx[n] <= '0;
            end
        end else begin
            r_vld <= {pm_valido_in, r_vld[NIVELES:1]};
            if (pm_valido_in) begin
                r_mod[NIVELES] <= pm_modo_min;
            end
            for (int d = 1; d < NIVELES; d++) begin
                if (r_vld[d+1]) begin
                    r_mod[d] <= r_mod[d+1];
                end
            end
            for (int n = 0; n < NODOS; n++) begin
                if (w_en[n]) begin
                    r_val[n] <= w_val_next[n];
                    r_idx[n] <= w_idx_next[n];
                end
            end
        end
    end

`ifdef PALABRA_MAYOR_EMPATE_EN
    // Tie flags follow the same enables as the payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tie <= '0;
        end else begin
            for (int n = 0; n < NODOS; n++) begin
                if (w_en[n]) begin
                    r_tie[n] <= w_tie_next[n];
                end
            end
        end
    end
    assign pm_empate = r_tie[0];
`else
    assign pm_empate = 1'b0;
`endif

    assign pm_mayor      = r_val[0];
    assign pm_indice     = r_idx[0];
    assign pm_valido_out = r_vld[0];

endmodule
